branch_resolve: RTL

- Sequential branch resolution unit in the execute stage.
- Accepts one branch or jump per handshake from decode, and evaluates the condition using the shared COM_OP_* comparison encoding from defs.vh.
- Compares the outcome with the fetch-side prediction and issues a redirect plus a pipeline flush to fetch on mispredict.
- Also returns the link value (pc+4) for JAL/JALR writeback.

---
 rtl/branch_resolve.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: evaluates the condition, checks the prediction, redirects fetch.
// Optional counters: define BRANCH_RESOLVE_STATS_EN for stat_branches/stat_taken/stat_mispred.
module branch_resolve #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic            kill,
    output logic            res_valid,
    output logic            res_taken,
    output logic [XLEN-1:0] res_link,
    output logic            res_misalign,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispred
`endif
);

    localparam logic [2:0] COM_OP_EQ  = 3'b000;
    localparam logic [2:0] COM_OP_NE  = 3'b001;
    localparam logic [2:0] COM_OP_LT  = 3'b100;
    localparam logic [2:0] COM_OP_GE  = 3'b101;
    localparam logic [2:0] COM_OP_LTU = 3'b110;
    localparam logic [2:0] COM_OP_GEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            jal_q, jal_d;
    logic            jalr_q, jalr_d;
    logic            pred_q, pred_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            cond_c;
    logic            taken_c;
    logic            misalign_c;
    logic            mispred_c;
    logic [XLEN-1:0] jalr_sum_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;
    logic [XLEN-1:0] fix_pc_c;

    // Resolution datapath, operating only on the captured operands
    always_comb begin
        cond_c = 1'b0;
        case (op_q)
            COM_OP_EQ:  cond_c = (rs1_q == rs2_q);
            COM_OP_NE:  cond_c = (rs1_q != rs2_q);
            COM_OP_LT:  cond_c = ($signed(rs1_q) <  $signed(rs2_q));
            COM_OP_GE:  cond_c = ($signed(rs1_q) >= $signed(rs2_q));
            COM_OP_LTU: cond_c = (rs1_q <  rs2_q);
            COM_OP_GEU: cond_c = (rs1_q >= rs2_q);
            default:    cond_c = 1'b0;
        endcase
        taken_c    = jal_q | jalr_q | cond_c;
        jalr_sum_c = rs1_q + imm_q;
        target_c   = jalr_q ? {jalr_sum_c[XLEN-1:1], 1'b0} : (pc_q + imm_q);
        link_c     = pc_q + XLEN'(4);
        misalign_c = taken_c & target_c[1];
        mispred_c  = !misalign_c && (taken_c != pred_q);
        fix_pc_c   = taken_c ? target_c : link_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'b000;
            jal_q      <= 1'b0;
            jalr_q     <= 1'b0;
            pred_q     <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            jal_q      <= jal_d;
            jalr_q     <= jalr_d;
            pred_q     <= pred_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Next state and outputs; kill overrides every other event
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        jal_d        = jal_q;
        jalr_d       = jalr_q;
        pred_d       = pred_q;
        pc_d         = pc_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        imm_d        = imm_q;
        redir_pc_d   = redir_pc_q;
        in_ready     = 1'b0;
        res_valid    = 1'b0;
        res_taken    = 1'b0;
        res_link     = '0;
        res_misalign = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        flush        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = !kill;
                if (!kill && in_valid) begin
                    op_d    = in_op;
                    jal_d   = in_jal;
                    jalr_d  = in_jalr;
                    pred_d  = in_pred_taken;
                    pc_d    = in_pc;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    imm_d   = in_imm;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    res_valid    = 1'b1;
                    res_taken    = taken_c;
                    res_link     = link_c;
                    res_misalign = misalign_c;
                    state_d      = ST_IDLE;
                    if (mispred_c) begin
                        flush       = 1'b1;
                        redir_valid = 1'b1;
                        redir_pc    = fix_pc_c;
                        redir_pc_d  = fix_pc_c;
                        if (!redir_ready) begin
                            state_d = ST_REDIRECT;
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                redir_valid = 1'b1;
                redir_pc    = redir_pc_q;
                if (kill || redir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Saturating event counters
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_taken_d    = stat_taken_q;
        stat_mispred_d  = stat_mispred_q;
        if (res_valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (res_valid && res_taken && (stat_taken_q != 32'hFFFF_FFFF)) begin
            stat_taken_d = stat_taken_q + 32'd1;
        end
        if (flush && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_branches_q <= 32'd0;
            stat_taken_q    <= 32'd0;
            stat_mispred_q  <= 32'd0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_taken_q    <= stat_taken_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_taken    = stat_taken_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
